// File: rtl/spi_flash_seq.sv
// Flash operation sequencer: WREN, erase/program, then status polling through a single-IO SPI engine.
// Defining SPI_SEQ_TIMEOUT_EN adds a per-operation poll counter that ends the op with err after POLL_LIMIT polls.
module spi_flash_seq #(
    parameter int MAXCMD     = 260,
    parameter int POLL_LIMIT = 2000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [1:0]          op_code,
    input  logic [23:0]         op_addr,
    input  logic [8:0]          op_len,
    input  logic [2047:0]       op_data,
    output logic                done,
    output logic                err,
    output logic [7:0]          status,
    output logic                cmd_trigger,
    input  logic                cmd_busy,
    output logic [11:0]         cmd_in_count,
    output logic [11:0]         cmd_out_count,
    output logic [MAXCMD*8-1:0] cmd_data,
    input  logic [63:0]         cmd_data_out,
    output logic                cmd_quad,
    output logic [2:0]          dbg_state,
    output logic [1:0]          dbg_phase
);
    localparam int CW = MAXCMD * 8;
    localparam int FW = 32 + 2048;

    typedef enum logic [2:0] {S_IDLE, S_WREN, S_CMD, S_POLL, S_FIN} state_t;
    typedef enum logic [1:0] {P_ISSUE, P_WAIT_HI, P_WAIT_LO} phase_t;

    // Engine handshake: ISSUE pulses cmd_trigger for one cycle while cmd_busy=0 with
    // cmd_data/counts already registered; WAIT_HI waits for busy=1, WAIT_LO for busy=0.
    // Frames stay untouched until the WAIT_LO exit of the transaction using them.
    state_t        r_state, w_state_nx;
    phase_t        r_phase, w_phase_nx;
    logic [1:0]    r_code;
    logic [23:0]   r_addr;
    logic [8:0]    r_len;
    logic [2047:0] r_data;
    logic          r_err;
    logic [7:0]    r_status;
    logic [11:0]   r_in_count;
    logic [11:0]   r_out_count;
    logic [CW-1:0] r_cmd_data;

    logic          w_accept;
    logic          w_illegal;
    logic          w_trigger;
    logic          w_txn_end;
    logic          w_wip;
    logic          w_timeout;
    logic [8:0]    w_pad;
    logic [11:0]   w_shamt;
    logic [FW-1:0] w_prog_full;
    logic [FW-1:0] w_prog_frame;
    logic [CW-1:0] w_cmd_frame;
    logic [11:0]   w_cmd_in_count;
    logic          w_unused;

    assign op_ready  = (r_state == S_IDLE) && !cmd_busy && !reset;
    assign w_accept  = op_valid && op_ready;
    assign w_illegal = (op_code == 2'b11) ||
                       ((op_code == 2'b10) && ((op_len == 9'd0) || (op_len > 9'd256)));
    assign w_txn_end = ((r_state == S_WREN) || (r_state == S_CMD) || (r_state == S_POLL)) &&
                       (r_phase == P_WAIT_LO) && !cmd_busy;
    assign w_wip     = cmd_data_out[0];
    assign w_unused  = ^cmd_data_out[63:8];

    // Program frame: opcode, address and all 256 data bytes, shifted right so only the
    // first r_len data bytes remain, right-aligned with zeros above.
    assign w_pad          = 9'd256 - r_len;
    assign w_shamt        = {w_pad, 3'b000};
    assign w_prog_full    = {8'h02, r_addr, r_data};
    assign w_prog_frame   = w_prog_full >> w_shamt;
    assign w_cmd_frame    = r_code[1] ? CW'(w_prog_frame)
                                      : CW'({(r_code[0] ? 8'h20 : 8'hD8), r_addr});
    assign w_cmd_in_count = r_code[1] ? ({r_len, 3'b000} + 12'd31) : 12'd31;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int PCW = $clog2(POLL_LIMIT + 1);
    logic [PCW-1:0] r_poll_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_poll_cnt <= '0;
        end else if (w_accept) begin
            r_poll_cnt <= '0;
        end else if (w_txn_end && (r_state == S_POLL)) begin
            r_poll_cnt <= r_poll_cnt + PCW'(1);
        end
    end

    // The poll now finishing is the POLL_LIMIT-th one.
    assign w_timeout = (r_poll_cnt == PCW'(POLL_LIMIT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_trigger  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = w_illegal ? S_FIN : S_WREN;
                    w_phase_nx = P_ISSUE;
                end
            end
            S_WREN, S_CMD, S_POLL: begin
                case (r_phase)
                    P_ISSUE: begin
                        if (!cmd_busy) begin
                            w_trigger  = 1'b1;
                            w_phase_nx = P_WAIT_HI;
                        end
                    end
                    P_WAIT_HI: begin
                        if (cmd_busy) w_phase_nx = P_WAIT_LO;
                    end
                    P_WAIT_LO: begin
                        if (!cmd_busy) begin
                            w_phase_nx = P_ISSUE;
                            case (r_state)
                                S_WREN:  w_state_nx = S_CMD;
                                S_CMD:   w_state_nx = S_POLL;
                                default: w_state_nx = (!w_wip || w_timeout) ? S_FIN : S_POLL;
                            endcase
                        end
                    end
                    default: w_phase_nx = P_ISSUE;
                endcase
            end
            S_FIN:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_phase     <= P_ISSUE;
            r_code      <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_data      <= '0;
            r_err       <= 1'b0;
            r_status    <= 8'h00;
            r_in_count  <= '0;
            r_out_count <= '0;
            r_cmd_data  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_phase <= w_phase_nx;
            if (w_accept) begin
                r_code <= op_code;
                r_addr <= op_addr;
                r_len  <= op_len;
                r_data <= op_data;
                r_err  <= w_illegal;
            end
            if (w_accept && !w_illegal) begin
                r_cmd_data  <= CW'(8'h06);
                r_in_count  <= 12'd7;
                r_out_count <= 12'd0;
            end
            if (w_txn_end) begin
                case (r_state)
                    S_WREN: begin
                        r_cmd_data  <= w_cmd_frame;
                        r_in_count  <= w_cmd_in_count;
                        r_out_count <= 12'd0;
                    end
                    S_CMD: begin
                        r_cmd_data  <= CW'(8'h05);
                        r_in_count  <= 12'd7;
                        r_out_count <= 12'd8;
                    end
                    S_POLL: begin
                        r_status <= cmd_data_out[7:0];
                        if (w_wip && w_timeout) r_err <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_trigger   = w_trigger && !reset;
    assign done          = (r_state == S_FIN) && !reset;
    assign err           = r_err;
    assign status        = r_status;
    assign cmd_in_count  = r_in_count;
    assign cmd_out_count = r_out_count;
    assign cmd_data      = r_cmd_data;
    assign cmd_quad      = 1'b0;
    assign dbg_state     = r_state;
    assign dbg_phase     = r_phase;
endmodule
